score_sprite_drawer: RTL and testbench

SCORE_SPRITE_DRAWER -- requirements
Module: score_sprite_drawer

---
 rtl/score_sprite_drawer.sv | 160 ++++++++++++++++
 tb/tb_score_sprite_drawer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_sprite_drawer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : score_sprite_drawer                                           |
// | Purpose  : Overlays a keyed (transparent-colour) sprite from a digit ROM |
// |            onto a VGA background with a fixed 3-clock pixel pipeline.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   i_clk2         sole clock, rising edge                                 |
// |   i_rst          synchronous active-high reset                           |
// |   i_x, i_y       current VGA pixel column / row                          |
// |   i_video_on     high in the visible area                                |
// |   i_frame_start  one-cycle pulse; latches i_pos_x/i_pos_y/i_show         |
// |   i_pos_x/y      requested sprite top-left corner                        |
// |   i_show         requested sprite visibility                             |
// |   i_bg_rgb       background colour (RGB 3-3-2)                           |
// |   o_numberaddr   digit ROM address (registered)                          |
// |   i_numberdata   digit ROM data, one clock after the address             |
// |   o_rgb          final pixel colour, 3 clocks after i_x/i_y              |
// |   o_hit          o_rgb is an opaque sprite pixel                         |
// +--------------------------------------------------------------------------+
module score_sprite_drawer #(
  parameter int         SPRITE_W  = 20,
  parameter int         SPRITE_H  = 20,
  parameter logic [7:0] KEY_COLOR = 8'h00
) (
  input  logic       i_clk2,
  input  logic       i_rst,
  input  logic [9:0] i_x,
  input  logic [9:0] i_y,
  input  logic       i_video_on,
  input  logic       i_frame_start,
  input  logic [9:0] i_pos_x,
  input  logic [9:0] i_pos_y,
  input  logic       i_show,
  input  logic [7:0] i_bg_rgb,
  output logic [9:0] o_numberaddr,
  input  logic [7:0] i_numberdata,
  output logic [7:0] o_rgb,
  output logic       o_hit
);

  localparam logic [10:0] C_W11 = 11'(SPRITE_W);
  localparam logic [10:0] C_H11 = 11'(SPRITE_H);

  // Shadow copy of the requested position, updated only on frame start so a
  // position change never tears a frame.
  logic [9:0] r_px;
  logic [9:0] r_py;
  logic       r_show;

  always_ff @(posedge i_clk2) begin
    if (i_rst) begin
      r_px   <= '0;
      r_py   <= '0;
      r_show <= 1'b0;
    end else if (i_frame_start) begin
      r_px   <= i_pos_x;
      r_py   <= i_pos_y;
      r_show <= i_show;
    end
  end

  // Box test in 11 bits so a sprite near column/row 1023 does not wrap.
  logic [10:0] w_x_end;
  logic [10:0] w_y_end;
  logic        w_in_box;

  assign w_x_end  = {1'b0, r_px} + C_W11;
  assign w_y_end  = {1'b0, r_py} + C_H11;
  assign w_in_box = r_show & i_video_on
                  & ({1'b0, i_x} >= {1'b0, r_px}) & ({1'b0, i_x} < w_x_end)
                  & ({1'b0, i_y} >= {1'b0, r_py}) & ({1'b0, i_y} < w_y_end);

  // Sprite-local offsets; only meaningful when w_in_box is set.
  logic [9:0] w_dx;
  logic [9:0] w_dy;
  logic [9:0] w_row_off;
  logic [9:0] w_addr;

  assign w_dx = i_x - r_px;
  assign w_dy = i_y - r_py;

  generate
    if (SPRITE_W == 20) begin : g_mul_shift
      // dy*20 = dy*16 + dy*4, kept off the DSP blocks.
      assign w_row_off = (w_dy << 4) + (w_dy << 2);
    end else begin : g_mul_generic
      assign w_row_off = w_dy * 10'(SPRITE_W);
    end
  endgenerate

  assign w_addr = w_row_off + w_dx;

  // Stage 1: address plus the flags that travel alongside it.
  logic       r1_in_box;
  logic       r1_video_on;
  logic [7:0] r1_bg;

  always_ff @(posedge i_clk2) begin
    if (i_rst) begin
      o_numberaddr <= '0;
      r1_in_box    <= 1'b0;
      r1_video_on  <= 1'b0;
      r1_bg        <= '0;
    end else begin
      o_numberaddr <= w_in_box ? w_addr : '0;
      r1_in_box    <= w_in_box;
      r1_video_on  <= i_video_on;
      r1_bg        <= i_bg_rgb;
    end
  end

  // Stage 2: the ROM samples the address; flags wait one more clock.
  logic       r2_in_box;
  logic       r2_video_on;
  logic [7:0] r2_bg;

  always_ff @(posedge i_clk2) begin
    if (i_rst) begin
      r2_in_box   <= 1'b0;
      r2_video_on <= 1'b0;
      r2_bg       <= '0;
    end else begin
      r2_in_box   <= r1_in_box;
      r2_video_on <= r1_video_on;
      r2_bg       <= r1_bg;
    end
  end

  // Stage 3: colour select. Blanking overrides everything, then opaque
  // sprite pixels override the background.
  logic [7:0] w_rgb;
  logic       w_hit;

  always_comb begin
    w_rgb = 8'h00;
    w_hit = 1'b0;
    if (r2_video_on) begin
      if (r2_in_box && (i_numberdata != KEY_COLOR)) begin
        w_rgb = i_numberdata;
        w_hit = 1'b1;
      end else begin
        w_rgb = r2_bg;
      end
    end
  end

  always_ff @(posedge i_clk2) begin
    if (i_rst) begin
      o_rgb <= 8'h00;
      o_hit <= 1'b0;
    end else begin
      o_rgb <= w_rgb;
      o_hit <= w_hit;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_score_sprite_drawer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_score_sprite_drawer                                        |
// | Purpose  : Self-checking bench for score_sprite_drawer with a ROM model, |
// |            constant vector table, directed sequences and random pixels.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_score_sprite_drawer;

  localparam int         W   = 20;
  localparam int         H   = 20;
  localparam logic [7:0] KEY = 8'h00;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] x, y, posx, posy;
  logic       von, fs, show;
  logic [7:0] bg;
  logic [9:0] addr;
  logic [7:0] rom_q;
  logic [7:0] rgb;
  logic       hit;

  always #5 clk = ~clk;

  score_sprite_drawer #(.SPRITE_W(W), .SPRITE_H(H), .KEY_COLOR(KEY)) dut (
    .i_clk2        (clk),
    .i_rst         (rst),
    .i_x           (x),
    .i_y           (y),
    .i_video_on    (von),
    .i_frame_start (fs),
    .i_pos_x       (posx),
    .i_pos_y       (posy),
    .i_show        (show),
    .i_bg_rgb      (bg),
    .o_numberaddr  (addr),
    .i_numberdata  (rom_q),
    .o_rgb         (rgb),
    .o_hit         (hit)
  );

  // Synchronous digit ROM: data one clock after the address.
  logic [7:0] rom [0:1023];
  always @(posedge clk) rom_q <= rom[addr];

  typedef struct {
    logic [9:0] addr;
    logic [7:0] rgb;
    logic       hit;
  } rec_t;

  rec_t hist [3];
  int   sh_px, sh_py;
  bit   sh_show;
  int   n_err = 0;
  int   n_chk = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Expected outcome of the pixel currently on the inputs, from the
  // geometric rules with plain integer arithmetic.
  function automatic rec_t model();
    rec_t r;
    int   ix = int'(x);
    int   iy = int'(y);
    bit   inb;
    int   a;
    inb = sh_show && von && ix >= sh_px && ix < sh_px + W
                         && iy >= sh_py && iy < sh_py + H;
    a = inb ? ((iy - sh_py) * W + (ix - sh_px)) % 1024 : 0;
    r.addr = 10'(a);
    if (!von) begin
      r.rgb = 8'h00; r.hit = 1'b0;
    end else if (inb && rom[a] != KEY) begin
      r.rgb = rom[a]; r.hit = 1'b1;
    end else begin
      r.rgb = bg;     r.hit = 1'b0;
    end
    return r;
  endfunction

  // One clock: advance the model, clock the DUT, compare address (1 clock
  // latency) and colour/hit (3 clock latency).
  task automatic step();
    if (rst) begin
      for (int i = 0; i < 3; i++) hist[i] = '{10'd0, 8'd0, 1'b0};
      sh_px = 0; sh_py = 0; sh_show = 1'b0;
    end else begin
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = model();
      if (fs) begin
        sh_px = int'(posx); sh_py = int'(posy); sh_show = show;
      end
    end
    @(posedge clk);
    #1;
    chk("m_addr", addr, hist[0].addr);
    chk("m_rgb",  rgb,  hist[2].rgb);
    chk("m_hit",  hit,  hist[2].hit);
  endtask

  task automatic idle(input int n);
    von = 1'b0; fs = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic frame(input logic [9:0] px, input logic [9:0] py, input logic sh);
    posx = px; posy = py; show = sh; fs = 1'b1; von = 1'b0;
    step();
    fs = 1'b0;
  endtask

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       von;
    logic [7:0] bg;
    logic [9:0] e_addr;
    logic [7:0] e_rgb;
    logic       e_hit;
  } vec_t;

  vec_t tbl [8];
  int   hits;

  initial begin
    // sprite at (100,50): addr = dy*20 + dx
    tbl[0] = '{10'd100, 10'd50, 1'b1, 8'h03, 10'd0,   8'h5A, 1'b1};
    tbl[1] = '{10'd119, 10'd69, 1'b1, 8'h03, 10'd399, 8'h5A, 1'b1};
    tbl[2] = '{10'd105, 10'd52, 1'b1, 8'h03, 10'd45,  8'hE0, 1'b1};
    tbl[3] = '{10'd120, 10'd52, 1'b1, 8'h03, 10'd0,   8'h03, 1'b0};
    tbl[4] = '{10'd110, 10'd55, 1'b1, 8'h1F, 10'd110, 8'h1F, 1'b0};
    tbl[5] = '{10'd99,  10'd50, 1'b1, 8'h44, 10'd0,   8'h44, 1'b0};
    tbl[6] = '{10'd100, 10'd70, 1'b1, 8'h44, 10'd0,   8'h44, 1'b0};
    tbl[7] = '{10'd105, 10'd52, 1'b0, 8'h33, 10'd0,   8'h00, 1'b0};

    for (int i = 0; i < 1024; i++) rom[i] = 8'h5A;
    rom[45]  = 8'hE0;
    rom[110] = 8'h00;
    for (int i = 0; i < 3; i++) hist[i] = '{10'd0, 8'd0, 1'b0};
    sh_px = 0; sh_py = 0; sh_show = 1'b0;

    rst = 1'b1; x = '0; y = '0; von = 1'b0; fs = 1'b0;
    posx = '0; posy = '0; show = 1'b0; bg = '0;

    // Reset state.
    step(); step();
    chk("rst_addr", addr, 0);
    chk("rst_rgb",  rgb,  0);
    chk("rst_hit",  hit,  0);
    rst = 1'b0;
    idle(2);

    // Vector table: one pixel, then blanking until its colour emerges.
    frame(10'd100, 10'd50, 1'b1);
    for (int i = 0; i < 8; i++) begin
      x = tbl[i].x; y = tbl[i].y; von = tbl[i].von; bg = tbl[i].bg;
      step();
      chk("tbl_addr", addr, tbl[i].e_addr);
      von = 1'b0;
      step(); step();
      chk("tbl_rgb", rgb, tbl[i].e_rgb);
      chk("tbl_hit", hit, tbl[i].e_hit);
    end

    // Position change without frame start is ignored until the next frame.
    posx = 10'd300; posy = 10'd200;
    x = 10'd105; y = 10'd52; von = 1'b1; bg = 8'h03;
    step(); von = 1'b0; step(); step();
    chk("hold_rgb", rgb, 8'hE0);
    chk("hold_hit", hit, 1);
    x = 10'd300; y = 10'd200; von = 1'b1;
    step(); von = 1'b0; step(); step();
    chk("hold_newpos_hit", hit, 0);
    frame(10'd300, 10'd200, 1'b1);
    x = 10'd300; y = 10'd200; von = 1'b1;
    step(); von = 1'b0; step(); step();
    chk("moved_hit", hit, 1);
    chk("moved_rgb", rgb, 8'h5A);

    // Reset mid-sprite drops everything and hides the sprite until re-armed.
    frame(10'd100, 10'd50, 1'b1);
    x = 10'd105; y = 10'd52; von = 1'b1; bg = 8'h03;
    step();
    rst = 1'b1; x = 10'd106;
    step();
    chk("mid_rst_addr", addr, 0);
    chk("mid_rst_rgb",  rgb,  0);
    chk("mid_rst_hit",  hit,  0);
    rst = 1'b0;
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      x = 10'(100 + i); y = 10'd55; von = 1'b1;
      step();
      if (hit) hits++;
    end
    for (int i = 0; i < 3; i++) begin
      von = 1'b0; step();
      if (hit) hits++;
    end
    chk("post_rst_hits", hits, 0);
    frame(10'd100, 10'd50, 1'b1);
    x = 10'd105; y = 10'd52; von = 1'b1;
    step(); von = 1'b0; step(); step();
    chk("rearm_hit", hit, 1);
    chk("rearm_rgb", rgb, 8'hE0);

    // Right-edge clipping: sprite at column 630 shows only columns 630..639.
    for (int i = 0; i < 1024; i++) rom[i] = 8'h5A;
    frame(10'd630, 10'd10, 1'b1);
    hits = 0;
    for (int i = 620; i < 650; i++) begin
      x = 10'(i); y = 10'd12; von = (i < 640); bg = 8'h11;
      step();
      if (hit) hits++;
    end
    for (int i = 0; i < 3; i++) begin
      von = 1'b0; step();
      if (hit) hits++;
    end
    chk("edge_hits", hits, 10);
    hits = 0;
    for (int i = 0; i < 12; i++) begin
      x = 10'(i); y = 10'd12; von = 1'b1;
      step();
      if (hit) hits++;
    end
    idle(3);
    chk("edge_nowrap_hits", hits, 0);

    // Randomized pixels against the model.
    for (int i = 0; i < 1024; i++)
      rom[i] = ($urandom_range(0, 3) == 0) ? KEY : 8'($urandom);
    idle(3);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        posx = ($urandom_range(0, 9) == 0) ? 10'd1015 : 10'($urandom_range(0, 660));
        posy = ($urandom_range(0, 9) == 0) ? 10'd1015 : 10'($urandom_range(0, 490));
        show = ($urandom_range(0, 4) != 0);
      end
      fs  = ($urandom_range(0, 29) == 0);
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) begin
        x = 10'($urandom); y = 10'($urandom);
      end else begin
        x = 10'(sh_px + $urandom_range(0, W + 4) - 2);
        y = 10'(sh_py + $urandom_range(0, H + 4) - 2);
      end
      von = ($urandom_range(0, 9) == 0) ? 1'($urandom) : ((x < 10'd640) && (y < 10'd480));
      bg  = 8'($urandom);
      step();
    end
    rst = 1'b0;
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
